// File: rtl/hififo_pcie_lite.sv
`default_nettype none
// ============================================================================
// Module   : hififo_pcie_lite
// Purpose  : PCIe PIO endpoint (64-bit AXIS TLPs): register file, from-PC
//            word port and a 16-deep to-PC FIFO read back by the host.
// Revision : 1.0
// ============================================================================
module hififo_pcie_lite #(
    parameter int TPC_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        pci_reset,
    input  logic [15:0] pci_id,
    output logic        interrupt_out,
    input  logic        s_axis_tx_tready,
    output logic [63:0] s_axis_tx_tdata,
    output logic        s_axis_tx_1dw,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        m_axis_rx_tvalid,
    input  logic        m_axis_rx_tlast,
    input  logic [63:0] m_axis_rx_tdata,
    output logic        tpc0_reset,
    input  logic [63:0] tpc0_data,
    input  logic        tpc0_write,
    output logic        tpc0_ready,
    output logic        fpc0_reset,
    output logic [63:0] fpc0_data,
    input  logic        fpc0_read,
    output logic        fpc0_valid
);

    localparam logic [TPC_DEPTH_LOG2:0]   c_depth   = {1'b1, {TPC_DEPTH_LOG2{1'b0}}};
    localparam logic [TPC_DEPTH_LOG2:0]   c_cnt_one = (TPC_DEPTH_LOG2+1)'(1);
    localparam logic [TPC_DEPTH_LOG2-1:0] c_ptr_one = TPC_DEPTH_LOG2'(1);
    localparam logic [7:0]                c_fmt_mwr = 8'h40;
    localparam logic [7:0]                c_fmt_mrd = 8'h00;

    typedef enum logic [1:0] {RX_HDR = 2'd0, RX_BODY = 2'd1, RX_SKIP = 2'd2} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_BEAT0 = 2'd1, TX_BEAT1 = 2'd2} tx_state_t;

    rx_state_t r_rx_state;
    tx_state_t r_tx_state;
    logic        r_rx_is_wr;
    logic [15:0] r_req_id;
    logic [7:0]  r_tag;

    logic [2:0]  r_ctrl;
    logic [31:0] r_scratch;
    logic [31:0] r_fpc_lo;
    logic [63:0] r_fpc_data;
    logic        r_fpc_valid;
    logic        r_fpc_ovf;

    logic [63:0]               r_mem [0:(1<<TPC_DEPTH_LOG2)-1];
    logic [TPC_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [TPC_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [TPC_DEPTH_LOG2:0]   r_tpc_count;

    logic [63:0] r_tx_data;
    logic [63:0] r_cpl_beat1;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic        r_irq;

    logic        w_hdr_mwr;
    logic        w_hdr_mrd;
    logic        w_body;
    logic        w_wr_en;
    logic        w_rd_en;
    logic [2:0]  w_idx;
    logic [31:0] w_wdata;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_fpc_pop;
    logic        w_fpc_hi_wr;
    logic        w_status_wr;
    logic [63:0] w_head;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_hdr_mwr    = (m_axis_rx_tdata[31:24] == c_fmt_mwr) && (m_axis_rx_tdata[9:0] == 10'd1);
    assign w_hdr_mrd    = (m_axis_rx_tdata[31:24] == c_fmt_mrd) && (m_axis_rx_tdata[9:0] == 10'd1);
    assign w_body       = (r_rx_state == RX_BODY) && m_axis_rx_tvalid;
    assign w_wr_en      = w_body && r_rx_is_wr;
    // A read arriving while a completion is still in flight is dropped whole.
    assign w_rd_en      = w_body && !r_rx_is_wr && (r_tx_state == TX_IDLE);
    assign w_idx        = m_axis_rx_tdata[4:2];
    assign w_wdata      = m_axis_rx_tdata[63:32];
    assign w_fifo_empty = (r_tpc_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_push       = tpc0_write && tpc0_ready;
    assign w_pop        = w_rd_en && (w_idx == 3'd7) && !w_fifo_empty;
    assign w_fpc_pop    = fpc0_read && r_fpc_valid;
    assign w_fpc_hi_wr  = w_wr_en && (w_idx == 3'd5);
    assign w_status_wr  = w_wr_en && (w_idx == 3'd1);

    always_comb begin
        w_status        = '0;
        w_status[0]     = !w_fifo_empty;
        w_status[8:4]   = 5'(r_tpc_count);
        w_status[16]    = r_fpc_valid;
        w_status[17]    = r_fpc_ovf;
        w_rdata         = '0;
        case (w_idx)
            3'd0:    w_rdata = {29'b0, r_ctrl};
            3'd1:    w_rdata = w_status;
            3'd2:    w_rdata = r_scratch;
            3'd6:    w_rdata = w_fifo_empty ? 32'h0 : w_head[31:0];
            3'd7:    w_rdata = w_fifo_empty ? 32'h0 : w_head[63:32];
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) begin
            r_rx_state <= RX_HDR;
            r_rx_is_wr <= 1'b0;
            r_req_id   <= '0;
            r_tag      <= '0;
        end else if (m_axis_rx_tvalid) begin
            case (r_rx_state)
                RX_HDR: begin
                    r_rx_is_wr <= w_hdr_mwr;
                    r_req_id   <= m_axis_rx_tdata[63:48];
                    r_tag      <= m_axis_rx_tdata[47:40];
                    if (m_axis_rx_tlast)
                        r_rx_state <= RX_HDR;
                    else if (w_hdr_mwr || w_hdr_mrd)
                        r_rx_state <= RX_BODY;
                    else
                        r_rx_state <= RX_SKIP;
                end
                RX_BODY: r_rx_state <= m_axis_rx_tlast ? RX_HDR : RX_SKIP;
                RX_SKIP: if (m_axis_rx_tlast) r_rx_state <= RX_HDR;
                default: r_rx_state <= RX_HDR;
            endcase
        end
    end

    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) begin
            r_ctrl    <= '0;
            r_scratch <= '0;
            r_fpc_lo  <= '0;
        end else if (w_wr_en) begin
            case (w_idx)
                3'd0:    r_ctrl    <= w_wdata[2:0];
                3'd2:    r_scratch <= w_wdata;
                3'd4:    r_fpc_lo  <= w_wdata;
                default: ;
            endcase
        end
    end

    // A new word is accepted only if the slot is empty or being drained this cycle.
    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) begin
            r_fpc_data  <= '0;
            r_fpc_valid <= 1'b0;
            r_fpc_ovf   <= 1'b0;
        end else if (r_ctrl[2]) begin
            r_fpc_valid <= 1'b0;
            r_fpc_ovf   <= 1'b0;
        end else begin
            if (w_fpc_hi_wr && r_fpc_valid && !w_fpc_pop)
                r_fpc_ovf <= 1'b1;
            else if (w_status_wr)
                r_fpc_ovf <= 1'b0;
            if (w_fpc_hi_wr && (!r_fpc_valid || w_fpc_pop)) begin
                r_fpc_data  <= {w_wdata, r_fpc_lo};
                r_fpc_valid <= 1'b1;
            end else if (w_fpc_pop) begin
                r_fpc_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tpc_count <= '0;
        end else if (r_ctrl[1]) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tpc_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_tpc_count <= r_tpc_count + c_cnt_one;
                2'b01:   r_tpc_count <= r_tpc_count - c_cnt_one;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= tpc0_data;
    end

    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_data   <= '0;
            r_cpl_beat1 <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: if (w_rd_en) begin
                    r_tx_data   <= {pci_id, 16'h0004, 32'h4A000001};
                    r_cpl_beat1 <= {w_rdata, r_req_id, r_tag, 1'b0, m_axis_rx_tdata[6:0]};
                    r_tx_valid  <= 1'b1;
                    r_tx_last   <= 1'b0;
                    r_tx_state  <= TX_BEAT0;
                end
                TX_BEAT0: if (s_axis_tx_tready) begin
                    r_tx_data  <= r_cpl_beat1;
                    r_tx_last  <= 1'b1;
                    r_tx_state <= TX_BEAT1;
                end
                TX_BEAT1: if (s_axis_tx_tready) begin
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge pci_reset) begin
        if (!pci_reset) r_irq <= 1'b0;
        else            r_irq <= r_ctrl[0] && !w_fifo_empty;
    end

    assign interrupt_out    = r_irq;
    assign s_axis_tx_tdata  = r_tx_data;
    assign s_axis_tx_tvalid = r_tx_valid;
    assign s_axis_tx_tlast  = r_tx_last;
    assign s_axis_tx_1dw    = 1'b0;
    assign tpc0_reset       = r_ctrl[1];
    assign fpc0_reset       = r_ctrl[2];
    assign tpc0_ready       = !r_ctrl[1] && (r_tpc_count < c_depth);
    assign fpc0_data        = r_fpc_data;
    assign fpc0_valid       = r_fpc_valid;

endmodule
`default_nettype wire

// File: tb/tb_hififo_pcie_lite.sv
`default_nettype none
// ============================================================================
// Module   : tb_hififo_pcie_lite
// Purpose  : Self-checking bench: register vectors, FIFO/fpc corner sequences,
//            completion scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hififo_pcie_lite;

    localparam logic [15:0] c_pci_id = 16'hDEAD;
    localparam logic [15:0] c_req    = 16'h0100;
    localparam logic [63:0] c_cpl_b0 = 64'hDEAD0004_4A000001;

    logic        clock = 1'b0;
    logic        pci_reset;
    logic        interrupt_out;
    logic        tx_tready;
    logic [63:0] tx_tdata;
    logic        tx_1dw;
    logic        tx_tlast;
    logic        tx_tvalid;
    logic        rx_valid;
    logic        rx_last;
    logic [63:0] rx_data;
    logic        tpc0_reset;
    logic [63:0] tpc0_data;
    logic        tpc0_write;
    logic        tpc0_ready;
    logic        fpc0_reset;
    logic [63:0] fpc0_data;
    logic        fpc0_read;
    logic        fpc0_valid;

    logic        loop_en;
    logic        tb_tpc_write;
    logic [63:0] tb_tpc_data;
    logic        tb_fpc_read;
    logic        seq_move;

    // Loopback sequencer: forward each from-PC word straight into the to-PC FIFO.
    assign seq_move   = loop_en && fpc0_valid && tpc0_ready;
    assign tpc0_write = loop_en ? seq_move  : tb_tpc_write;
    assign tpc0_data  = loop_en ? fpc0_data : tb_tpc_data;
    assign fpc0_read  = loop_en ? seq_move  : tb_fpc_read;

    always #5 clock = ~clock;

    hififo_pcie_lite #(.TPC_DEPTH_LOG2(4)) dut (
        .clock            (clock),
        .pci_reset        (pci_reset),
        .pci_id           (c_pci_id),
        .interrupt_out    (interrupt_out),
        .s_axis_tx_tready (tx_tready),
        .s_axis_tx_tdata  (tx_tdata),
        .s_axis_tx_1dw    (tx_1dw),
        .s_axis_tx_tlast  (tx_tlast),
        .s_axis_tx_tvalid (tx_tvalid),
        .m_axis_rx_tvalid (rx_valid),
        .m_axis_rx_tlast  (rx_last),
        .m_axis_rx_tdata  (rx_data),
        .tpc0_reset       (tpc0_reset),
        .tpc0_data        (tpc0_data),
        .tpc0_write       (tpc0_write),
        .tpc0_ready       (tpc0_ready),
        .fpc0_reset       (fpc0_reset),
        .fpc0_data        (fpc0_data),
        .fpc0_read        (fpc0_read),
        .fpc0_valid       (fpc0_valid)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  tag;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    vec_t  tv[15];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Completion monitor: every accepted TX beat must match the queue head.
    always @(negedge clock) begin
        if (tx_tvalid === 1'b1 && tx_tready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL cpl_unexpected: got beat %h, expected none", tx_tdata);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("cpl_data", tx_tdata, e.data);
                chk("cpl_last_1dw", {62'b0, tx_tlast, tx_1dw}, {62'b0, e.last, 1'b0});
            end
        end
    end

    task automatic rx_beat(input logic [63:0] d, input logic last);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
    endtask

    task automatic rx_idle();
        @(posedge clock); #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic send_mwr(input logic [31:0] addr, input logic [31:0] data);
        rx_beat({c_req, 8'h00, 8'h0F, 32'h4000_0001}, 1'b0);
        rx_beat({data, addr}, 1'b1);
        rx_idle();
    endtask

    task automatic send_mrd_raw(input logic [31:0] addr, input logic [7:0] tag);
        rx_beat({c_req, tag, 8'h0F, 32'h0000_0001}, 1'b0);
        rx_beat({32'h0, addr}, 1'b1);
        rx_idle();
    endtask

    task automatic expect_cpl(input logic [31:0] addr, input logic [7:0] tag, input logic [31:0] exp);
        sb_q.push_back('{c_cpl_b0, 1'b0});
        sb_q.push_back('{{exp, c_req, tag, 1'b0, addr[6:0]}, 1'b1});
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb_q.size() != 0 || tx_tvalid) && k < 200) begin
            @(posedge clock);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL cpl_timeout: got %0d beats outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] tag, input logic [31:0] exp);
        expect_cpl(addr, tag, exp);
        send_mrd_raw(addr, tag);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pci_reset    = 1'b0;
        tx_tready    = 1'b1;
        rx_valid     = 1'b0;
        rx_last      = 1'b0;
        rx_data      = '0;
        loop_en      = 1'b0;
        tb_tpc_write = 1'b0;
        tb_tpc_data  = '0;
        tb_fpc_read  = 1'b0;

        tv[0]  = '{1'b1, 32'h08, 32'h12345678, 8'h00};
        tv[1]  = '{1'b0, 32'h08, 32'h12345678, 8'h05};
        tv[2]  = '{1'b0, 32'h00, 32'h00000000, 8'h10};
        tv[3]  = '{1'b1, 32'h00, 32'hFFFFFFF8, 8'h00};
        tv[4]  = '{1'b0, 32'h00, 32'h00000000, 8'h11};
        tv[5]  = '{1'b1, 32'h00, 32'h000000F9, 8'h00};
        tv[6]  = '{1'b0, 32'h00, 32'h00000001, 8'h12};
        tv[7]  = '{1'b1, 32'h00, 32'h00000000, 8'h00};
        tv[8]  = '{1'b1, 32'h0C, 32'hDEADBEEF, 8'h00};
        tv[9]  = '{1'b0, 32'h0C, 32'h00000000, 8'h13};
        tv[10] = '{1'b0, 32'h28, 32'h12345678, 8'h14};
        tv[11] = '{1'b0, 32'h1C, 32'h00000000, 8'h15};
        tv[12] = '{1'b0, 32'h04, 32'h00000000, 8'h16};
        tv[13] = '{1'b1, 32'h18, 32'h0000FFFF, 8'h00};
        tv[14] = '{1'b0, 32'h18, 32'h00000000, 8'h17};

        repeat (4) @(posedge clock);
        #1 pci_reset = 1'b1;
        @(negedge clock);
        chk("rst_tvalid", {63'b0, tx_tvalid}, 64'd0);
        chk("rst_fpc_valid", {63'b0, fpc0_valid}, 64'd0);
        chk("rst_tpc_ready", {63'b0, tpc0_ready}, 64'd1);
        chk("rst_irq", {63'b0, interrupt_out}, 64'd0);

        for (int i = 0; i < 15; i++) begin
            if (tv[i].wr) send_mwr(tv[i].addr, tv[i].data);
            else          do_read(tv[i].addr, tv[i].tag, tv[i].data);
        end

        // Non-matching TLPs must be skipped to tlast without touching registers.
        rx_beat({c_req, 8'h00, 8'h0F, 32'h6000_0001}, 1'b0);
        rx_beat({32'hBAD0BAD0, 32'h0000_0008}, 1'b0);
        rx_beat({32'hBAD0BAD0, 32'h0000_0000}, 1'b1);
        rx_beat({c_req, 8'h00, 8'h0F, 32'h4000_0002}, 1'b0);
        rx_beat({32'hBAD1BAD1, 32'h0000_0008}, 1'b0);
        rx_beat({32'hBAD1BAD1, 32'h0000_0000}, 1'b1);
        rx_idle();
        do_read(32'h08, 8'h18, 32'h12345678);

        send_mwr(32'h10, 32'hCAFEBABE);
        send_mwr(32'h14, 32'h01234567);
        @(negedge clock);
        chk("fpc_valid_set", {63'b0, fpc0_valid}, 64'd1);
        chk("fpc_data", fpc0_data, 64'h01234567_CAFEBABE);
        send_mwr(32'h14, 32'h89ABCDEF);
        @(negedge clock);
        chk("fpc_data_kept", fpc0_data, 64'h01234567_CAFEBABE);
        do_read(32'h04, 8'h20, 32'h0003_0000);
        @(posedge clock); #1 tb_fpc_read = 1'b1;
        @(posedge clock); #1 tb_fpc_read = 1'b0;
        @(negedge clock);
        chk("fpc_valid_clr", {63'b0, fpc0_valid}, 64'd0);
        do_read(32'h04, 8'h21, 32'h0002_0000);
        send_mwr(32'h04, 32'h0);
        do_read(32'h04, 8'h22, 32'h0000_0000);
        send_mwr(32'h00, 32'h4);
        send_mwr(32'h14, 32'h55555555);
        @(negedge clock);
        chk("fpc_reset_out", {63'b0, fpc0_reset}, 64'd1);
        chk("fpc_reset_hold", {63'b0, fpc0_valid}, 64'd0);
        send_mwr(32'h00, 32'h0);

        // 17 push attempts: the last must be refused by a full FIFO.
        for (int i = 0; i < 17; i++) begin
            @(posedge clock); #1;
            tb_tpc_write = 1'b1;
            tb_tpc_data  = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
        end
        @(posedge clock); #1 tb_tpc_write = 1'b0;
        @(negedge clock);
        chk("tpc_full_ready", {63'b0, tpc0_ready}, 64'd0);
        do_read(32'h04, 8'h30, 32'h0000_0101);
        send_mwr(32'h00, 32'h1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("irq_set", {63'b0, interrupt_out}, 64'd1);
        do_read(32'h18, 8'h31, 32'hB000_0000);
        do_read(32'h1C, 8'h32, 32'hA000_0000);
        @(negedge clock);
        chk("tpc_ready_after_pop", {63'b0, tpc0_ready}, 64'd1);
        do_read(32'h04, 8'h33, 32'h0000_00F1);
        do_read(32'h18, 8'h34, 32'hB000_0001);
        send_mwr(32'h00, 32'h2);
        @(negedge clock);
        chk("tpc_reset_ready", {63'b0, tpc0_ready}, 64'd0);
        chk("tpc_reset_out", {63'b0, tpc0_reset}, 64'd1);
        do_read(32'h04, 8'h35, 32'h0000_0000);
        send_mwr(32'h00, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("tpc_ready_back", {63'b0, tpc0_ready}, 64'd1);
        chk("irq_clr", {63'b0, interrupt_out}, 64'd0);

        loop_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_mwr(32'h10, 32'h7000_0000 + 32'(k));
            send_mwr(32'h14, 32'h5000_0000 + 32'(k));
        end
        repeat (3) @(posedge clock);
        for (int k = 0; k < 8; k++) begin
            do_read(32'h18, 8'h40 + 8'(k), 32'h7000_0000 + 32'(k));
            do_read(32'h1C, 8'h50 + 8'(k), 32'h5000_0000 + 32'(k));
        end
        loop_en = 1'b0;
        do_read(32'h04, 8'h5F, 32'h0000_0000);

        // Back-pressure: beat0 must hold; a read during the stall is dropped.
        @(posedge clock); #1 tx_tready = 1'b0;
        expect_cpl(32'h08, 8'h60, 32'h12345678);
        send_mrd_raw(32'h08, 8'h60);
        send_mrd_raw(32'h08, 8'h61);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_tvalid", {63'b0, tx_tvalid}, 64'd1);
            chk("stall_beat0", tx_tdata, c_cpl_b0);
            chk("stall_tlast", {63'b0, tx_tlast}, 64'd0);
        end
        @(posedge clock); #1 tx_tready = 1'b1;
        wait_drain();
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("no_second_cpl", {63'b0, tx_tvalid}, 64'd0);

        // Reset in the middle of a write: the header is lost, the decoder restarts.
        rx_beat({c_req, 8'h00, 8'h0F, 32'h4000_0001}, 1'b0);
        @(posedge clock); #1;
        rx_valid  = 1'b0;
        pci_reset = 1'b0;
        @(negedge clock);
        chk("rst_fpc_data", fpc0_data, 64'd0);
        repeat (2) @(posedge clock);
        #1 pci_reset = 1'b1;
        do_read(32'h08, 8'h70, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
